// File: rtl/program_memory_pkg.sv
// Shared types and constants for the loadable instruction memory.
// Imported by the top level and the bench.
package program_memory_pkg;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    localparam int XLEN = 16;
    localparam logic [XLEN-1:0] NOP_WORD = '0;

endpackage

// File: rtl/program_memory_if.sv
// Loader and fetch handshake bundle for program_memory.
// master = fetch/loader side, slave = memory side.
interface program_memory_if #(
    parameter int l = 16
);

    logic         LoadEnable;
    logic [l-1:0] LoadAddress;
    logic [l-1:0] LoadData;
    logic         LoadReady;
    logic         FetchValid;
    logic [l-1:0] FetchAddress;
    logic         FetchReady;
    logic         InstrValid;
    logic         InstrReady;
    logic [l-1:0] Instruction;
    logic         Fault;

    modport master (
        output LoadEnable, LoadAddress, LoadData,
        output FetchValid, FetchAddress, InstrReady,
        input  LoadReady, FetchReady,
        input  InstrValid, Instruction, Fault
    );

    modport slave (
        input  LoadEnable, LoadAddress, LoadData,
        input  FetchValid, FetchAddress, InstrReady,
        output LoadReady, FetchReady,
        output InstrValid, Instruction, Fault
    );

endinterface

// File: rtl/program_memory_array.sv
// 1-write/1-read synchronous RAM with registered read data and no reset,
// shaped so a vendor block RAM can drop in.
module program_memory_array #(
    parameter int l     = 16,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [l-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [l-1:0]  rdata
);

    logic [l-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/program_memory.sv
// Loadable synchronous-read instruction memory with a post-reset
// clear sequencer, fetch handshake and out-of-range fault flag.
module program_memory
    import program_memory_pkg::*;
#(
    parameter  int l     = 16,
    parameter  int DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic Clock,
    input  logic Reset,
    program_memory_if.slave bus
);

    localparam logic [l:0]    DEPTH_W = (l+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
    localparam logic [l-1:0]  NOP     = l'(NOP_WORD);

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] cnt;

    logic          load_rdy;
    logic          fetch_rdy;
    logic          load_in;
    logic          fetch_in;
    logic          accept;

    logic          we;
    logic [AW-1:0] waddr;
    logic [l-1:0]  wdata;
    logic          re;
    logic [l-1:0]  rdata;

    logic          ivalid;
    logic          fault;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= CLEAR;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            CLEAR:   if (cnt == LAST) state_nx = RUN;
            RUN:     state_nx = RUN;
            default: state_nx = CLEAR;
        endcase
    end

    always_comb begin
        load_rdy  = (state == RUN);
        fetch_rdy = load_rdy && !bus.LoadEnable &&
                    (!ivalid || bus.InstrReady);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt <= '0;
        end else if (state == CLEAR) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Full-width compares so upper address bits never alias into the array.
    assign load_in  = ({1'b0, bus.LoadAddress} < DEPTH_W);
    assign fetch_in = ({1'b0, bus.FetchAddress} < DEPTH_W);
    assign accept   = bus.FetchValid && fetch_rdy;

    always_comb begin
        if (state == CLEAR) begin
            we    = 1'b1;
            waddr = cnt;
            wdata = NOP;
        end else begin
            we    = bus.LoadEnable && load_in;
            waddr = bus.LoadAddress[AW-1:0];
            wdata = bus.LoadData;
        end
    end

    assign re = accept && fetch_in;

    program_memory_array #(
        .l     (l),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (Clock),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .re    (re),
        .raddr (bus.FetchAddress[AW-1:0]),
        .rdata (rdata)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            ivalid <= 1'b0;
            fault  <= 1'b0;
        end else if (accept) begin
            ivalid <= 1'b1;
            fault  <= !fetch_in;
        end else if (bus.InstrReady) begin
            ivalid <= 1'b0;
        end
    end

    // Masking keeps the output at NOP out of reset and on faults
    // without putting a reset on the RAM read register.
    assign bus.Instruction = (ivalid && !fault) ? rdata : NOP;
    assign bus.Fault       = fault;
    assign bus.InstrValid  = ivalid;
    assign bus.LoadReady   = load_rdy;
    assign bus.FetchReady  = fetch_rdy;

endmodule

// File: doc/program_memory.md
# program_memory

Parametrised, loadable, synchronous-read instruction memory that replaces the fixed combinational instruction table. It sits between the fetch stage and a program loader: the loader writes instruction words, and fetch issues word addresses through a valid/ready handshake and receives registered instructions one cycle later. After reset, a built-in clear sequencer zeroes the array, so unloaded locations read as 0 (NOP) and out-of-range fetches are flagged rather than aliased.

## Interface
- l, 16, instruction and address width in bits; addresses are word addresses.
- DEPTH, 256, number of instruction words; power of two, 2 ≤ DEPTH ≤ 2^l.
- AW, $clog2(DEPTH), internal index width; derived, not overridden.

- Clock  in  1  single clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high.
- LoadEnable  in  1  write LoadData to LoadAddress this cycle; honoured only while LoadReady=1.
- LoadAddress  in  l  word address to write.
- LoadData  in  l  instruction word to write.
- LoadReady  out  1  1 when state is RUN.
- FetchValid  in  1  fetch request present.
- FetchAddress  in  l  word address to fetch.
- FetchReady  out  1  request accepted when FetchValid && FetchReady at a rising edge.
- InstrValid  out  1  Instruction/Fault hold a response.
- InstrReady  in  1  consumer takes the response when InstrValid && InstrReady.
- Instruction  out  l  fetched word; 0 when Fault=1.
- Fault  out  1  the response's address was ≥ DEPTH.

## Operation
- States are CLEAR and RUN. Reset forces CLEAR with clear counter 0. In CLEAR, each cycle writes 0 to array[counter] and increments the counter. The write of index DEPTH-1 moves the state to RUN. CLEAR never returns except through Reset.
- In CLEAR: LoadReady=0 and FetchReady=0. LoadEnable and FetchValid are ignored.
- Load (RUN only): if LoadEnable=1 and LoadAddress < DEPTH, the array word is written at the edge. If LoadAddress ≥ DEPTH, the write is silently dropped. No aliasing on the upper address bits.
- FetchReady = (state==RUN) && !LoadEnable && (!InstrValid || InstrReady). A load cycle stalls fetch, so a read and a write never share a cycle.
- On an accepted fetch, the response register loads at the same edge:
  - if FetchAddress < DEPTH: array[FetchAddress], Fault=0;
  - if FetchAddress ≥ DEPTH: Instruction=0, Fault=1.
- InstrValid is set by an accepted fetch. It is cleared when the response is taken without a new acceptance in the same cycle.
- While InstrValid && !InstrReady, Instruction and Fault hold stable.
- Simultaneous take and new fetch in the same cycle: the response is replaced back-to-back, giving one instruction per cycle.
- Reset mid-operation: any in-flight response is dropped, the clear sequence restarts from index 0, and all loaded contents are lost.

## Timing
- Reset values: InstrValid=0, Instruction=0, Fault=0, LoadReady=0, FetchReady=0.
- Clear duration: exactly DEPTH cycles after the first cycle with Reset=0. LoadReady and FetchReady first read 1 in cycle DEPTH, counting the first post-reset cycle as 0.
- Fetch latency: a request accepted at edge N gives InstrValid=1 with data from cycle N+1 onward.
- Throughput: 1 fetch/cycle when InstrReady=1 and no load is present. Each load cycle costs one fetch slot.
- Read-after-write: a load at edge N is visible to a fetch accepted at edge N+1 or later.
- The array has no combinational read path; Instruction is always driven from a register.

## Structure
- Shared package program_memory_pkg holds:
  - the state typedef {CLEAR, RUN};
  - the NOP_WORD constant (all zeros), used by both the clear sequencer and the fault response.
- Sub-module program_memory_array is a 1-write/1-read synchronous RAM (DEPTH × l, no reset), so a vendor block RAM can be substituted.
- The top level holds the FSM, clear counter, range checks, handshake logic and response register.

## Test plan
- Reset released, FetchValid=1 held: FetchReady stays 0 for DEPTH cycles. The first response is then addr 0 → Instruction=0x0000, Fault=0.
- Load addr 0=0x6002 and addr 1=0x6403, then fetch 0 and 1 back-to-back with InstrReady=1: responses 0x6002 then 0x6403 on consecutive cycles.
- Fetch addr DEPTH (256) → Instruction=0, Fault=1, InstrValid=1. A load to addr 256 leaves all words unchanged, checked by reading back 0x00–0xFF.
- Backpressure: fetch addr 1, hold InstrReady=0 for 3 cycles with FetchValid=1 at addr 2. FetchReady=0 and 0x6403 holds stable; on release, 0x6403 is taken, then addr 2 follows one cycle later.
- Load and fetch asserted in the same cycle: FetchReady=0 that cycle. The fetch is accepted next cycle and returns the newly loaded word.
- Assert Reset with a response pending, then release: InstrValid=0 at once, previously loaded addr 0 reads 0x0000 after the clear completes.
